wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Shares the single register-file write port between the pipeline write-back stage and a long-latency multi-cycle unit (mul/div) that returns results out of pipeline order. Write-back always wins; multi-cycle results are buffered in a small FIFO and drained into free write slots. A starvation counter requests a pipeline bubble when a buffered result waits too long. Busy flags let the hazard unit stall decode on registers with buffered results.

## Interface
- DEPTH, 2: FIFO entries for multi-cycle results; power of two, ≥ 2.
- MAX_WAIT, 4: consecutive blocked cycles before a bubble is requested; 1..15.

- CLK  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegWriteW  in  1  write-back stage write enable.
- WriteRegW  in  5  write-back destination register.
- ResultW  in  32  write-back data.
- mc_valid  in  1  multi-cycle unit presents a result.
- mc_reg  in  5  multi-cycle destination register.
- mc_data  in  32  multi-cycle result.
- mc_ready  out  1  result accepted this cycle.
- RsD, RtD  in  5 each  decode-stage source registers.
- BusyRs, BusyRt  out  1 each  source matches a valid buffered entry.
- StallReq  out  1  request a write-back bubble to drain the FIFO.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.

## Operation
- WB slot busy = RegWriteW && WriteRegW != 0. When busy: rf_we=1, rf_waddr=WriteRegW, rf_wdata=ResultW, combinationally in the same cycle. RegWriteW with WriteRegW=0 is dropped; slot counts as free.
- Slot free, FIFO holds a valid head: write head, pop on the edge.
- Slot free, FIFO empty, mc_valid, mc_reg≠0: bypass; write mc_data to mc_reg same cycle; nothing enqueued.
- Otherwise mc_valid && mc_ready && mc_reg≠0 enqueues at the edge. mc_reg=0 is accepted and discarded.
- mc_ready = !full (combinational). No enqueue while full, even if the head pops that cycle.
- Enqueue and pop may occur on the same edge; count updates by net change.
- Each entry has a valid bit. A head with valid=0 is popped in any cycle, including WB-busy cycles, without writing.
- BusyRs/BusyRt = source≠0 && any valid entry has reg == source. Bypass-cycle results do not raise Busy.
- wait_cnt, 4-bit saturating:
  - Increments each edge where a valid head exists and is not popped.
  - Clears on a pop or when the FIFO is empty.
- StallReq = (wait_cnt ≥ MAX_WAIT), driven from the register. It stays high until the head is written.
- Reset mid-operation: all buffered entries are lost. Upstream reissue is the multi-cycle unit's responsibility.

## Timing
- Reset values: FIFO empty, all valid bits 0, wait_cnt=0, StallReq=0, mc_ready=1, BusyRs=BusyRt=0. rf_we is forced 0 while rst is high.
- Latencies:
  - WB write: 0 cycles.
  - Bypass write: 0 cycles.
  - Enqueued entry: earliest write is the cycle after the enqueue edge.
- A head enqueued at edge 0 and blocked through cycles 1..4 gives wait_cnt=4 after edge 4. StallReq is high from cycle 5 (MAX_WAIT=4).
- FIFO pointers wrap modulo DEPTH. Full/empty is decided by an occupancy count of log2(DEPTH)+1 bits.

## Configuration
- WB_ARB_WAW_KILL_EN defined: a WB write to R clears the valid bit of every buffered entry with reg==R on that edge, so the younger WB value wins. An entry enqueued on the same edge with reg==R is still enqueued (the multi-cycle result is younger).
- Undefined: no invalidation. Buffered entries write later in FIFO order, and WAW ordering is the hazard unit's responsibility.

## Test plan
- Reset, then idle → mc_ready=1, rf_we=0, StallReq=0, BusyRs=BusyRt=0.
- Bypass: FIFO empty, WB idle, mc_valid with reg 5, data 0xDEADBEEF → same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; FIFO stays empty.
- Conflict: WB writes reg 3 = 0x11 while mc offers reg 7 = 0x22 → cycle 0 writes reg 3 and enqueues; with WB idle the next cycle writes reg 7 = 0x22. RsD=7 gives BusyRs=1 only between those edges.
- Full and starvation: WB busy continuously, 2 mc results (DEPTH=2), a third offered → mc_ready=0; StallReq=1 from cycle 5 after the first enqueue edge (MAX_WAIT=4). One WB-idle cycle writes the head and drops StallReq next cycle.
- WAW kill (macro on): buffer reg 9 = 0xAA, WB writes reg 9 = 0xBB → only 0xBB is written; the killed head pops without a write; BusyRs for 9 drops next cycle. With the macro off, 0xAA is written after 0xBB.
- Async reset asserted with 2 entries buffered → FIFO empty immediately, mc_ready=1, StallReq=0; no write of old entries after release.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Arbitrates the register-file write port between write-back and a multi-cycle unit.
// Optional WB_ARB_WAW_KILL_EN: a WB write invalidates older buffered results to the same register.
module wb_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        mc_valid,
    input  logic [4:0]  mc_reg,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    output logic        BusyRs,
    output logic        BusyRt,
    output logic        StallReq,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       ent_reg  [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] vld_next;
    logic [DEPTH-1:0] kill;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [3:0]       wait_cnt;

    logic wb_busy;
    logic empty;
    logic full;
    logic head_vld;
    logic head_write;
    logic bypass;
    logic pop;
    logic push;

    assign wb_busy    = RegWriteW && (WriteRegW != 5'd0);
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign head_vld   = !empty && ent_vld[rd_ptr];
    assign head_write = head_vld && !wb_busy;
    // An invalidated head is discarded even while write-back owns the port.
    assign pop        = !empty && (!ent_vld[rd_ptr] || !wb_busy);
    assign bypass     = !wb_busy && empty && mc_valid && (mc_reg != 5'd0);
    assign push       = mc_valid && !full && (mc_reg != 5'd0) && !bypass;

    assign mc_ready = !full;
    assign StallReq = (wait_cnt >= 4'(MAX_WAIT));

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (wb_busy) begin
                rf_we    = 1'b1;
                rf_waddr = WriteRegW;
                rf_wdata = ResultW;
            end else if (head_write) begin
                rf_we    = 1'b1;
                rf_waddr = ent_reg[rd_ptr];
                rf_wdata = ent_data[rd_ptr];
            end else if (bypass) begin
                rf_we    = 1'b1;
                rf_waddr = mc_reg;
                rf_wdata = mc_data;
            end
        end
    end

    always_comb begin
        BusyRs = 1'b0;
        BusyRt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (RsD != 5'd0) && (ent_reg[i] == RsD))
                BusyRs = 1'b1;
            if (ent_vld[i] && (RtD != 5'd0) && (ent_reg[i] == RtD))
                BusyRt = 1'b1;
        end
    end

    always_comb begin
        kill = '0;
`ifdef WB_ARB_WAW_KILL_EN
        for (int i = 0; i < DEPTH; i++)
            kill[i] = wb_busy && (ent_reg[i] == WriteRegW);
`endif
    end

    // A same-edge enqueue to the killed register is younger, so set wins.
    always_comb begin
        vld_next = ent_vld & ~kill;
        if (pop)
            vld_next[rd_ptr] = 1'b0;
        if (push)
            vld_next[wr_ptr] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            ent_reg[wr_ptr]  <= mc_reg;
            ent_data[wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            ent_vld  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= 4'd0;
        end else begin
            ent_vld <= vld_next;
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop || empty)
                wait_cnt <= 4'd0;
            else if (head_vld && (wait_cnt != 4'hF))
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_wb_write_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        CLK = 1'b0;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic        mc_valid;
    logic [4:0]  mc_reg;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic [4:0]  RsD;
    logic [4:0]  RtD;
    logic        BusyRs;
    logic        BusyRt;
    logic        StallReq;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic        v;
    } ent_t;

    ent_t mq[$];
    int   mwait = 0;

    wb_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .rst(rst),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data),
        .mc_ready(mc_ready), .RsD(RsD), .RtD(RtD),
        .BusyRs(BusyRs), .BusyRt(BusyRt), .StallReq(StallReq),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 CLK = ~CLK;

    task automatic set_in(input logic rw, input logic [4:0] wr,
                          input logic [31:0] res, input logic mv,
                          input logic [4:0] mr, input logic [31:0] md,
                          input logic [4:0] rs, input logic [4:0] rt);
        RegWriteW = rw;
        WriteRegW = wr;
        ResultW   = res;
        mc_valid  = mv;
        mc_reg    = mr;
        mc_data   = md;
        RsD       = rs;
        RtD       = rt;
    endtask

    // Expected combinational outputs for the current inputs and model state.
    task automatic model_eval(output logic we, output logic [4:0] wa,
                              output logic [31:0] wd, output logic rdy,
                              output logic brs, output logic brt,
                              output logic stl);
        logic wbb;
        wbb = RegWriteW && (WriteRegW != 5'd0);
        we = 1'b0;
        wa = 5'd0;
        wd = 32'd0;
        if (!rst) begin
            if (wbb) begin
                we = 1'b1; wa = WriteRegW; wd = ResultW;
            end else if (mq.size() > 0 && mq[0].v) begin
                we = 1'b1; wa = mq[0].r; wd = mq[0].d;
            end else if (mq.size() == 0 && mc_valid && mc_reg != 5'd0) begin
                we = 1'b1; wa = mc_reg; wd = mc_data;
            end
        end
        rdy = (mq.size() < DEPTH);
        brs = 1'b0;
        brt = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].v && RsD != 5'd0 && mq[i].r == RsD) brs = 1'b1;
            if (mq[i].v && RtD != 5'd0 && mq[i].r == RtD) brt = 1'b1;
        end
        stl = (mwait >= MAX_WAIT);
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_commit();
        logic wbb, popped, byp, acc;
        int   n;
        if (rst) begin
            mq.delete();
            mwait = 0;
            return;
        end
        wbb    = RegWriteW && (WriteRegW != 5'd0);
        n      = mq.size();
        popped = (n > 0) && (!mq[0].v || !wbb);
        byp    = !wbb && n == 0 && mc_valid && mc_reg != 5'd0;
        acc    = mc_valid && n < DEPTH && mc_reg != 5'd0 && !byp;
`ifdef WB_ARB_WAW_KILL_EN
        if (wbb)
            foreach (mq[i])
                if (mq[i].r == WriteRegW) mq[i].v = 1'b0;
`endif
        if (popped) void'(mq.pop_front());
        if (acc) mq.push_back('{r: mc_reg, d: mc_data, v: 1'b1});
        if (popped || n == 0) mwait = 0;
        else if (mwait < 15) mwait++;
    endtask

    task automatic tick();
        model_commit();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        set_in(1, 5'd3, 32'h1234, 1, 5'd4, 32'h55, 5'd4, 5'd0);
        #1;
        total++;
        if (rf_we !== 1'b0) $display("FAIL rst_we_forced got %0b want 0", rf_we);
        else passed++;
        total++;
        if (mc_ready !== 1'b1) $display("FAIL rst_ready got %0b want 1", mc_ready);
        else passed++;
        tick();
        rst = 1'b0;
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd4, 5'd3);
        #1;
        total++;
        if (mc_ready !== 1'b1) $display("FAIL idle_ready got %0b want 1", mc_ready);
        else passed++;
        total++;
        if (rf_we !== 1'b0) $display("FAIL idle_we got %0b want 0", rf_we);
        else passed++;
        total++;
        if (StallReq !== 1'b0) $display("FAIL idle_stall got %0b want 0", StallReq);
        else passed++;
        total++;
        if ({BusyRs, BusyRt} !== 2'b00)
            $display("FAIL idle_busy got %b want 00", {BusyRs, BusyRt});
        else passed++;
        tick();
    endtask

    task automatic test_bypass();
        set_in(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        #1;
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL bypass_write got %0b/%0d/%h want 1/5/deadbeef",
                     rf_we, rf_waddr, rf_wdata);
        else passed++;
        total++;
        if (BusyRs !== 1'b0) $display("FAIL bypass_busy got %0b want 0", BusyRs);
        else passed++;
        tick();
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd5, 5'd0);
        #1;
        total++;
        if ({rf_we, BusyRs, mc_ready} !== 3'b001)
            $display("FAIL bypass_after got we/busy/rdy=%b want 001",
                     {rf_we, BusyRs, mc_ready});
        else passed++;
        tick();
    endtask

    task automatic test_conflict();
        set_in(1, 5'd3, 32'h11, 1, 5'd7, 32'h22, 5'd7, 5'd0);
        #1;
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11})
            $display("FAIL conflict_wb got %0b/%0d/%h want 1/3/11",
                     rf_we, rf_waddr, rf_wdata);
        else passed++;
        total++;
        if (BusyRs !== 1'b0) $display("FAIL conflict_busy0 got %0b want 0", BusyRs);
        else passed++;
        tick();
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd7, 5'd0);
        #1;
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h22})
            $display("FAIL conflict_drain got %0b/%0d/%h want 1/7/22",
                     rf_we, rf_waddr, rf_wdata);
        else passed++;
        total++;
        if (BusyRs !== 1'b1) $display("FAIL conflict_busy1 got %0b want 1", BusyRs);
        else passed++;
        tick();
        #1;
        total++;
        if ({rf_we, BusyRs} !== 2'b00)
            $display("FAIL conflict_after got we/busy=%b want 00", {rf_we, BusyRs});
        else passed++;
        tick();
    endtask

    task automatic test_full_starve();
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      set_in(1, 5'd1, 32'h100, 1, 5'd10, 32'hA0A0, 5'd0, 5'd0);
            else if (c == 1) set_in(1, 5'd1, 32'h101, 1, 5'd11, 32'hB0B0, 5'd0, 5'd0);
            else             set_in(1, 5'd1, 32'h102, 1, 5'd12, 32'hC0C0, 5'd0, 5'd0);
            #1;
            total++;
            if (mc_ready !== (c < 2))
                $display("FAIL full_ready c%0d got %0b want %0b", c, mc_ready, c < 2);
            else passed++;
            total++;
            if (StallReq !== (c >= 5))
                $display("FAIL starve_stall c%0d got %0b want %0b", c, StallReq, c >= 5);
            else passed++;
            tick();
        end
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd10, 5'd11);
        #1;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, StallReq} !== {1'b1, 5'd10, 32'hA0A0, 1'b1})
            $display("FAIL starve_drain got %0b/%0d/%h stall=%0b want 1/10/a0a0 1",
                     rf_we, rf_waddr, rf_wdata, StallReq);
        else passed++;
        total++;
        if ({BusyRs, BusyRt} !== 2'b11)
            $display("FAIL full_busy got %b want 11", {BusyRs, BusyRt});
        else passed++;
        tick();
        set_in(1, 5'd1, 32'h103, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        total++;
        if ({StallReq, mc_ready} !== 2'b01)
            $display("FAIL starve_release got stall/rdy=%b want 01", {StallReq, mc_ready});
        else passed++;
        tick();
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        total++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd11, 32'hB0B0})
            $display("FAIL starve_second got %0b/%0d/%h want 1/11/b0b0",
                     rf_we, rf_waddr, rf_wdata);
        else passed++;
        tick();
        #1;
        total++;
        if (rf_we !== 1'b0) $display("FAIL starve_empty got %0b want 0", rf_we);
        else passed++;
        tick();
    endtask

    task automatic test_waw();
        set_in(1, 5'd2, 32'h33, 1, 5'd9, 32'hAA, 5'd9, 5'd0);
        #1;
        tick();
        set_in(1, 5'd9, 32'hBB, 0, 5'd0, 32'd0, 5'd9, 5'd0);
        #1;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, BusyRs} !== {1'b1, 5'd9, 32'hBB, 1'b1})
            $display("FAIL waw_wb got %0b/%0d/%h busy=%0b want 1/9/bb 1",
                     rf_we, rf_waddr, rf_wdata, BusyRs);
        else passed++;
        tick();
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd9, 5'd0);
        #1;
`ifdef WB_ARB_WAW_KILL_EN
        total++;
        if ({rf_we, BusyRs} !== 2'b00)
            $display("FAIL waw_kill got we/busy=%b want 00", {rf_we, BusyRs});
        else passed++;
`else
        total++;
        if ({rf_we, rf_waddr, rf_wdata, BusyRs} !== {1'b1, 5'd9, 32'hAA, 1'b1})
            $display("FAIL waw_late got %0b/%0d/%h busy=%0b want 1/9/aa 1",
                     rf_we, rf_waddr, rf_wdata, BusyRs);
        else passed++;
`endif
        tick();
        #1;
        total++;
        if ({rf_we, BusyRs} !== 2'b00)
            $display("FAIL waw_after got we/busy=%b want 00", {rf_we, BusyRs});
        else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        set_in(1, 5'd1, 32'h1, 1, 5'd20, 32'h2020, 5'd0, 5'd0);
        #1;
        tick();
        set_in(1, 5'd1, 32'h2, 1, 5'd21, 32'h2121, 5'd0, 5'd0);
        #1;
        tick();
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd20, 5'd21);
        #1;
        total++;
        if ({BusyRs, BusyRt, mc_ready} !== 3'b110)
            $display("FAIL arst_pre got busy/rdy=%b want 110", {BusyRs, BusyRt, mc_ready});
        else passed++;
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({mc_ready, StallReq, rf_we, BusyRs, BusyRt} !== 5'b10000)
            $display("FAIL arst_now got rdy/stall/we/brs/brt=%b want 10000",
                     {mc_ready, StallReq, rf_we, BusyRs, BusyRt});
        else passed++;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if ({rf_we, BusyRs, BusyRt} !== 3'b000)
                $display("FAIL arst_after c%0d got we/brs/brt=%b want 000",
                         c, {rf_we, BusyRs, BusyRt});
            else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        logic        e_we, e_rdy, e_brs, e_brt, e_stl;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        int          pct;
        for (int c = 0; c < 400; c++) begin
            case ((c / 100) % 4)
                0:       pct = 30;
                1:       pct = 90;
                2:       pct = 60;
                default: pct = 95;
            endcase
            set_in(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0,
                   5'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                   5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            model_eval(e_we, e_wa, e_wd, e_rdy, e_brs, e_brt, e_stl);
            total++;
            if (rf_we !== e_we) $display("FAIL rnd_we c%0d got %0b want %0b", c, rf_we, e_we);
            else passed++;
            if (e_we) begin
                total++;
                if ({rf_waddr, rf_wdata} !== {e_wa, e_wd})
                    $display("FAIL rnd_wr c%0d got %0d/%h want %0d/%h",
                             c, rf_waddr, rf_wdata, e_wa, e_wd);
                else passed++;
            end
            total++;
            if (mc_ready !== e_rdy)
                $display("FAIL rnd_ready c%0d got %0b want %0b", c, mc_ready, e_rdy);
            else passed++;
            total++;
            if ({BusyRs, BusyRt} !== {e_brs, e_brt})
                $display("FAIL rnd_busy c%0d got %b want %b", c, {BusyRs, BusyRt}, {e_brs, e_brt});
            else passed++;
            total++;
            if (StallReq !== e_stl)
                $display("FAIL rnd_stall c%0d got %0b want %0b", c, StallReq, e_stl);
            else passed++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        test_reset();
        test_bypass();
        test_conflict();
        test_full_starve();
        test_waw();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
